// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: FSM state encoding, opcode
// constants, instruction field widths and small decode helpers.
package control_unit_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int OPC_W    = 4;
  localparam int REG_W    = 2;
  localparam int ULA_OP_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_IMM_REQ   = 4'd3,
    ST_IMM_USE   = 4'd4,
    ST_EXEC_A    = 4'd5,
    ST_EXEC_B    = 4'd6,
    ST_WRITEBACK = 4'd7,
    ST_HALT      = 4'd8
  } state_e;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_JZ   = 4'h3;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'h7;

  // Instruction byte layout: opcode[7:4], rd[3:2], rs[1:0].
  function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic [REG_W-1:0] rd_of(input logic [DATA_W-1:0] instr);
    return instr[3:2];
  endfunction

  function automatic logic [REG_W-1:0] rs_of(input logic [DATA_W-1:0] instr);
    return instr[1:0];
  endfunction

  // Any opcode with the top bit set is an ALU rd,rs operation.
  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    return opc[3];
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle of control-unit handshake, RAM and datapath strobe signals.
// master = the control unit, slave = datapath/RAM side.
interface control_unit_if;
  import control_unit_pkg::*;

  logic                start;
  logic                zero_flag;
  logic [DATA_W-1:0]   ram_data_out;
  logic                ram_enable;
  logic [ADDR_W-1:0]   ram_addr;
  logic                gp_read;
  logic                gp_write;
  logic [REG_W-1:0]    gp_sel;
  logic                grab_ula;
  logic                latch_ula;
  logic [ULA_OP_W-1:0] ula_operation;
  logic                bus_drive;
  logic [DATA_W-1:0]   bus_value;
  logic [ADDR_W-1:0]   pc;
  logic                busy;
  logic                halted;

  modport master (
    input  start, zero_flag, ram_data_out,
    output ram_enable, ram_addr, gp_read, gp_write, gp_sel, grab_ula,
           latch_ula, ula_operation, bus_drive, bus_value, pc, busy, halted
  );

  modport slave (
    output start, zero_flag, ram_data_out,
    input  ram_enable, ram_addr, gp_read, gp_write, gp_sel, grab_ula,
           latch_ula, ula_operation, bus_drive, bus_value, pc, busy, halted
  );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches bytes from RAM, decodes them
// and issues register-file / ULA / bus strobes. Outputs are decoded from
// the registered state so an asynchronous reset clears them at once.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  control_unit_if.master cu
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [OPC_W-1:0]    fetched_opc;
  logic [OPC_W-1:0]    ir_opc;

  assign fetched_opc = opcode_of(cu.ram_data_out);
  assign ir_opc      = opcode_of(ir_q);

  // Next-state, program counter and instruction register update.
  // The opcode is decoded straight from RAM data in DECODE, since ir is
  // only loaded at the end of that cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (cu.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d = cu.ram_data_out;
        pc_d = pc_q + 8'd1;
        if (is_alu(fetched_opc)) begin
          state_d = ST_EXEC_A;
        end else begin
          case (fetched_opc)
            OPC_LDI, OPC_JMP, OPC_JZ: state_d = ST_IMM_REQ;
            OPC_HALT:                 state_d = ST_HALT;
            OPC_NOP:                  state_d = ST_FETCH;
            default:                  state_d = ST_FETCH;
          endcase
        end
      end
      ST_IMM_REQ: begin
        state_d = ST_IMM_USE;
      end
      ST_IMM_USE: begin
        state_d = ST_FETCH;
        case (ir_opc)
          OPC_JMP: pc_d = cu.ram_data_out;
          OPC_JZ:  pc_d = cu.zero_flag ? cu.ram_data_out : pc_q + 8'd1;
          default: pc_d = pc_q + 8'd1;
        endcase
      end
      ST_EXEC_A:    state_d = ST_EXEC_B;
      ST_EXEC_B:    state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State, pc and ir registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Per-state strobe decode; everything not named for a state stays 0.
  always_comb begin
    cu.ram_enable    = 1'b0;
    cu.ram_addr      = pc_q;
    cu.gp_read       = 1'b0;
    cu.gp_write      = 1'b0;
    cu.gp_sel        = '0;
    cu.grab_ula      = 1'b0;
    cu.latch_ula     = 1'b0;
    cu.ula_operation = '0;
    cu.bus_drive     = 1'b0;
    cu.bus_value     = '0;
    cu.pc            = pc_q;
    cu.busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    cu.halted        = (state_q == ST_HALT);
    case (state_q)
      ST_FETCH, ST_IMM_REQ: begin
        cu.ram_enable = 1'b1;
      end
      ST_IMM_USE: begin
        if (ir_opc == OPC_LDI) begin
          cu.bus_drive = 1'b1;
          cu.bus_value = cu.ram_data_out;
          cu.gp_write  = 1'b1;
          cu.gp_sel    = rd_of(ir_q);
        end
      end
      ST_EXEC_A: begin
        cu.gp_read       = 1'b1;
        cu.gp_sel        = rd_of(ir_q);
        cu.ula_operation = {1'b0, ir_q[6:4]};
      end
      ST_EXEC_B: begin
        cu.gp_read       = 1'b1;
        cu.gp_sel        = rs_of(ir_q);
        cu.grab_ula      = 1'b1;
        cu.ula_operation = {1'b0, ir_q[6:4]};
      end
      ST_WRITEBACK: begin
        cu.latch_ula     = 1'b1;
        cu.gp_write      = 1'b1;
        cu.gp_sel        = rd_of(ir_q);
        cu.ula_operation = {1'b0, ir_q[6:4]};
      end
      default: ;
    endcase
  end

endmodule
